// File: rtl/loop_nest_ctrl_if.sv
// loop_nest_ctrl_if: control and index-stream bundle for the loop nest sequencer.
//
// Signals:
//   start, abort        job request / synchronous job cancel (controller -> sequencer)
//   lim0..lim2          inner/middle/outer loop limits, inclusive (controller -> sequencer)
//   busy, done          job running / one-cycle completion pulse (sequencer -> controller)
//   idx_valid/idx_ready index tuple handshake (sequencer <-> consumer)
//   idx0..idx2          inner/middle/outer indices
//   last0..last2        loop-end flags aligned with the indices
//
// Modports: master = sequencer side, slave = controller/consumer side.
interface loop_nest_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] lim0;
  logic [DATA_W-1:0] lim1;
  logic [DATA_W-1:0] lim2;
  logic              busy;
  logic              done;
  logic              idx_valid;
  logic              idx_ready;
  logic [DATA_W-1:0] idx0;
  logic [DATA_W-1:0] idx1;
  logic [DATA_W-1:0] idx2;
  logic              last0;
  logic              last1;
  logic              last2;

  modport master (
    input  start, abort, lim0, lim1, lim2, idx_ready,
    output busy, done, idx_valid, idx0, idx1, idx2, last0, last1, last2
  );

  modport slave (
    output start, abort, lim0, lim1, lim2, idx_ready,
    input  busy, done, idx_valid, idx0, idx1, idx2, last0, last1, last2
  );
endinterface

// File: rtl/loop_nest_ctrl.sv
// loop_nest_ctrl: three-level nested-loop sequencer (inner idx0, middle idx1, outer idx2).
//
// Limits are latched when a job starts; one index tuple is emitted per accepted
// valid/ready transfer and a one-cycle done pulse follows the final tuple.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   bus        loop_nest_ctrl_if.master (start/abort/limits in, busy/done out,
//              idx_valid/idx_ready handshake, idx0..2, last0..2)
//   stall_cnt  (only with LOOP_NEST_CTRL_STALL_CNT_EN) saturating count of
//              idx_valid && !idx_ready cycles in the current/last job
//
// Optional feature macro: LOOP_NEST_CTRL_STALL_CNT_EN.
module loop_nest_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  loop_nest_ctrl_if.master bus
`ifdef LOOP_NEST_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] lim0_q, lim0_d;
  logic [DATA_W-1:0] lim1_q, lim1_d;
  logic [DATA_W-1:0] lim2_q, lim2_d;
  logic [DATA_W-1:0] idx0_q, idx0_d;
  logic [DATA_W-1:0] idx1_q, idx1_d;
  logic [DATA_W-1:0] idx2_q, idx2_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic last0_w, last1_w, last2_w;
  logic xfer;

  // Flags come straight from registered indices and latched limits so they stay
  // aligned with the tuple; gated by valid so they read 0 outside a job.
  assign last0_w = valid_q && (idx0_q == lim0_q);
  assign last1_w = last0_w && (idx1_q == lim1_q);
  assign last2_w = last1_w && (idx2_q == lim2_q);
  assign xfer    = valid_q && bus.idx_ready;

  always_comb begin
    state_d = state_q;
    lim0_d  = lim0_q;
    lim1_d  = lim1_q;
    lim2_d  = lim2_q;
    idx0_d  = idx0_q;
    idx1_d  = idx1_q;
    idx2_d  = idx2_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          lim0_d  = bus.lim0;
          lim1_d  = bus.lim1;
          lim2_d  = bus.lim2;
          idx0_d  = '0;
          idx1_d  = '0;
          idx2_d  = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end

      StRun: begin
        if (xfer) begin
          if (last0_w) begin
            idx0_d = '0;
            if (last1_w) begin
              idx1_d = '0;
              if (last2_w) begin
                idx2_d  = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StDone;
              end else begin
                idx2_d = idx2_q + DATA_W'(1);
              end
            end else begin
              idx1_d = idx1_q + DATA_W'(1);
            end
          end else begin
            idx0_d = idx0_q + DATA_W'(1);
          end
        end
        // A transfer in the abort cycle still counts for the consumer, but the
        // job ends silently: abort overrides any move to DONE.
        if (bus.abort) begin
          idx0_d  = '0;
          idx1_d  = '0;
          idx2_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        idx0_d  = '0;
        idx1_d  = '0;
        idx2_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      lim0_q  <= '0;
      lim1_q  <= '0;
      lim2_q  <= '0;
      idx0_q  <= '0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim0_q  <= lim0_d;
      lim1_q  <= lim1_d;
      lim2_q  <= lim2_d;
      idx0_q  <= idx0_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef LOOP_NEST_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == StIdle && bus.start) begin
      stall_cnt_d = '0;
    end else if (valid_q && !bus.idx_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.idx_valid = valid_q;
  assign bus.idx0      = idx0_q;
  assign bus.idx1      = idx1_q;
  assign bus.idx2      = idx2_q;
  assign bus.last0     = last0_w;
  assign bus.last1     = last1_w;
  assign bus.last2     = last2_w;

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// tb_loop_nest_ctrl: directed, table-driven bench for loop_nest_ctrl.
module tb_loop_nest_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loop_nest_ctrl_if #(.DATA_W(W)) bus ();
`ifdef LOOP_NEST_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  loop_nest_ctrl #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LOOP_NEST_CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // {idx0, idx1, idx2, last0, last1, last2}
  typedef struct packed {
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic [W-1:0] i2;
    logic         l0;
    logic         l1;
    logic         l2;
  } tup_t;

  // Hand-written expected sequence for lim0=2, lim1=1, lim2=1.
  tup_t basic [12] = '{
    {8'd0, 8'd0, 8'd0, 3'b000},
    {8'd1, 8'd0, 8'd0, 3'b000},
    {8'd2, 8'd0, 8'd0, 3'b100},
    {8'd0, 8'd1, 8'd0, 3'b000},
    {8'd1, 8'd1, 8'd0, 3'b000},
    {8'd2, 8'd1, 8'd0, 3'b110},
    {8'd0, 8'd0, 8'd1, 3'b000},
    {8'd1, 8'd0, 8'd1, 3'b000},
    {8'd2, 8'd0, 8'd1, 3'b100},
    {8'd0, 8'd1, 8'd1, 3'b000},
    {8'd1, 8'd1, 8'd1, 3'b000},
    {8'd2, 8'd1, 8'd1, 3'b111}
  };

  tup_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   stalls   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tup_t cur();
    return {bus.idx0, bus.idx1, bus.idx2, bus.last0, bus.last1, bus.last2};
  endfunction

  // Expected tuple order for arbitrary limits, inner loop fastest.
  task automatic build(input int l0, input int l1, input int l2);
    exp_q.delete();
    for (int c = 0; c <= l2; c++)
      for (int b = 0; b <= l1; b++)
        for (int a = 0; a <= l0; a++)
          exp_q.push_back({W'(a), W'(b), W'(c), a == l0, (a == l0) && (b == l1),
                           (a == l0) && (b == l1) && (c == l2)});
  endtask

  task automatic start_job(input int l0, input int l1, input int l2);
    bus.lim0  = W'(l0);
    bus.lim1  = W'(l1);
    bus.lim2  = W'(l2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Consume exp_q; bp selects ready pattern 1,0,0,1,0,0...; poke pulses start and
  // changes the limits mid-job and pulses start again in DONE.
  task automatic run_seq(input string name, input bit bp, input bit poke);
    int k   = 0;
    int cyc = 0;
    stalls = 0;
    while (k < exp_q.size() && cyc < 2000) begin
      check({name, " tuple"}, {62'(0), bus.idx_valid, bus.busy, cur()}, {62'(0), 2'b11, exp_q[k]});
      bus.idx_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (poke && cyc == 4) begin
        bus.start = 1'b1;
        bus.lim0  = 8'd7;
        bus.lim1  = 8'd5;
        bus.lim2  = 8'd3;
      end
      if (bus.idx_ready) k++;
      else stalls++;
      tick();
      bus.start = 1'b0;
      cyc++;
    end
    check({name, " count"}, 64'(k), 64'(exp_q.size()));
    check({name, " done"}, {bus.done, bus.busy, bus.idx_valid, bus.last2, bus.idx0, bus.idx1,
                            bus.idx2}, {4'b1000, 24'd0});
    if (poke) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({name, " idle"}, {bus.done, bus.busy, bus.idx_valid}, 3'b000);
    tick();
    check({name, " no rerun"}, {bus.done, bus.busy, bus.idx_valid}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.idx_ready = 1'b0;
    bus.lim0      = '0;
    bus.lim1      = '0;
    bus.lim2      = '0;
    rst           = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset outputs", {bus.busy, bus.done, bus.idx_valid, bus.idx0, bus.idx1, bus.idx2,
                            bus.last0, bus.last1, bus.last2}, '0);
`ifdef LOOP_NEST_CTRL_STALL_CNT_EN
    check("reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("idle after reset", {bus.busy, bus.done, bus.idx_valid}, 3'b000);

    // Basic job, ready tied high.
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(basic[i]);
    start_job(2, 1, 1);
    run_seq("basic", 1'b0, 1'b0);

    // Backpressure plus ignored start/limit changes.
    start_job(2, 1, 1);
    run_seq("backpressure", 1'b1, 1'b1);
`ifdef LOOP_NEST_CTRL_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif

    // All-zero limits: one tuple, busy for one cycle.
    build(0, 0, 0);
    start_job(0, 0, 0);
`ifdef LOOP_NEST_CTRL_STALL_CNT_EN
    check("stall_cnt cleared", 64'(stall_cnt), 64'd0);
`endif
    run_seq("zero", 1'b0, 1'b0);

    // Abort after 5 transfers.
    build(3, 3, 3);
    start_job(3, 3, 3);
    bus.idx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("abort pre", {bus.idx_valid, cur()}, {1'b1, exp_q[i]});
      tick();
    end
    check("abort tuple5", {bus.idx_valid, cur()}, {1'b1, exp_q[5]});
    bus.idx_ready = 1'b0;
    bus.abort     = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort idle", {bus.idx_valid, bus.busy, bus.done, bus.idx0, bus.idx1, bus.idx2,
                         bus.last2}, '0);
    tick();
    check("abort no done", {bus.done, bus.busy, bus.idx_valid}, 3'b000);

    // Abort together with the final transfer: no done pulse.
    start_job(0, 0, 0);
    bus.idx_ready = 1'b1;
    bus.abort     = 1'b1;
    check("abort+xfer last2", {bus.idx_valid, bus.last2}, 2'b11);
    tick();
    bus.abort = 1'b0;
    check("abort+xfer idle", {bus.done, bus.busy, bus.idx_valid}, 3'b000);
    tick();
    check("abort+xfer no done", {bus.done, bus.busy, bus.idx_valid}, 3'b000);

    // Fresh job after abort.
    build(1, 0, 0);
    start_job(1, 0, 0);
    run_seq("restart", 1'b0, 1'b0);

    // Asynchronous reset mid-tuple while stalled.
    build(2, 1, 1);
    start_job(2, 1, 1);
    bus.idx_ready = 1'b0;
    tick();
    tick();
    check("stall hold", {bus.idx_valid, cur()}, {1'b1, exp_q[0]});
    #2 rst = 1'b0;
    #1;
    check("async reset", {bus.busy, bus.done, bus.idx_valid, bus.idx0, bus.idx1, bus.idx2,
                          bus.last0, bus.last1, bus.last2}, '0);
    #2 rst = 1'b1;
    tick();
    check("idle after async", {bus.busy, bus.done, bus.idx_valid}, 3'b000);
    build(0, 0, 0);
    start_job(0, 0, 0);
    run_seq("post reset", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
